// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer widths, pixel type and write-arbiter state encoding
package fb_pkg;
    localparam int FB_ADDR_W = 10;
    localparam int FB_DATA_W = 24;
    localparam int FB_DEPTH  = 1024;
    typedef logic [FB_DATA_W-1:0] pixel_t;
    typedef enum logic {ST_ARB, ST_CLEAR} arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; last_grant names the loser of a tie
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~valid[1] | last_grant);
    assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of frame-buffer port A with a registered write stage
// FB_WRITE_ARBITER_CLEAR_EN adds the full-buffer clear sweep driven by CLEAR_START/CLEAR_BUSY
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int                ADDR_W      = FB_ADDR_W,
    parameter int                DATA_W      = FB_DATA_W,
    parameter int                DEPTH       = FB_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    input  logic              CLEAR_START,
    output logic              CLEAR_BUSY,
    output logic              FB_EN,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [DATA_W-1:0] FB_DIN
);
    logic [1:0]        grant;
    logic              last_grant;
    logic              arb_en;
    logic              clear_wr;
    logic              xfer;
    logic [ADDR_W-1:0] clear_addr;

    rr_arb2 u_rr_arb2 (
        .valid      ({REQ1_VALID, REQ0_VALID}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign REQ0_READY = arb_en & grant[0];
    assign REQ1_READY = arb_en & grant[1];
    assign xfer       = REQ0_READY | REQ1_READY;

`ifdef FB_WRITE_ARBITER_CLEAR_EN
    arb_state_e      state, state_nx;
    logic [ADDR_W:0] cnt, cnt_nx;
    logic            last_cnt;

    // one extra counter bit lets DEPTH reach 2**ADDR_W without the compare aliasing
    assign last_cnt = cnt == (ADDR_W+1)'(DEPTH - 1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == ST_ARB && CLEAR_START)
            state_nx = ST_CLEAR;
        if (state == ST_CLEAR) begin
            state_nx = last_cnt ? ST_ARB : ST_CLEAR;
            cnt_nx   = last_cnt ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_ARB;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // a clear request takes the cycle away from both requesters
    assign arb_en     = ~RESET & (state == ST_ARB) & ~CLEAR_START;
    assign clear_wr   = state == ST_CLEAR;
    assign clear_addr = cnt[ADDR_W-1:0];
    assign CLEAR_BUSY = clear_wr;
`else
    logic unused_clear;

    assign unused_clear = CLEAR_START ^ (^CLEAR_COLOR) ^ (DEPTH == 0);
    assign arb_en       = ~RESET;
    assign clear_wr     = 1'b0;
    assign clear_addr   = '0;
    assign CLEAR_BUSY   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_grant <= 1'b1;
            FB_EN      <= 1'b0;
            FB_WE      <= 1'b0;
            FB_ADDR    <= '0;
            FB_DIN     <= '0;
        end else begin
            FB_EN <= xfer | clear_wr;
            FB_WE <= xfer | clear_wr;
            if (clear_wr) begin
                FB_ADDR <= clear_addr;
                FB_DIN  <= CLEAR_COLOR;
            end else if (xfer) begin
                FB_ADDR <= REQ1_READY ? REQ1_ADDR : REQ0_ADDR;
                FB_DIN  <= REQ1_READY ? REQ1_DATA : REQ0_DATA;
            end
            if (xfer)
                last_grant <= REQ1_READY;
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed stimulus, per-cycle behavioural model check plus literal spot checks
module tb_fb_write_arbiter;
    localparam int          AW    = 10;
    localparam int          DW    = 24;
    localparam int          DEPTH = 1024;
    localparam logic [23:0] COLOR = 24'h0A0B0C;
`ifdef FB_WRITE_ARBITER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0, CLEAR_START = 1'b0;
    logic [AW-1:0] REQ0_ADDR = '0, REQ1_ADDR = '0;
    logic [DW-1:0] REQ0_DATA = '0, REQ1_DATA = '0;
    logic          REQ0_READY, REQ1_READY, CLEAR_BUSY, FB_EN, FB_WE;
    logic [AW-1:0] FB_ADDR;
    logic [DW-1:0] FB_DIN;

    int n_cmp = 0;
    int n_bad = 0;

    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_COLOR(COLOR)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA),
        .CLEAR_START(CLEAR_START), .CLEAR_BUSY(CLEAR_BUSY),
        .FB_EN(FB_EN), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DIN(FB_DIN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected port contents now, grant history, and clear cycles still to run.
    int          m_last = 1;
    int          m_left = 0;
    logic        m_en = 1'b0;
    logic [9:0]  m_addr = '0;
    logic [23:0] m_din = '0;

    always @(negedge CLK) begin
        int  win;
        bit  busy;
        if (RESET) begin
            m_last = 1; m_left = 0; m_en = 1'b0; m_addr = '0; m_din = '0;
        end
        busy = m_left > 0;
        win  = -1;
        if (REQ0_VALID && REQ1_VALID) win = 1 - m_last;
        else if (REQ0_VALID) win = 0;
        else if (REQ1_VALID) win = 1;
        if (RESET || busy || (CLR && CLEAR_START)) win = -1;
        chk("m_ready0", 32'(REQ0_READY), 32'(win == 0));
        chk("m_ready1", 32'(REQ1_READY), 32'(win == 1));
        chk("m_busy",   32'(CLEAR_BUSY), 32'(busy));
        chk("m_en",     32'(FB_EN),      32'(m_en));
        chk("m_we",     32'(FB_WE),      32'(m_en));
        chk("m_addr",   32'(FB_ADDR),    32'(m_addr));
        chk("m_din",    32'(FB_DIN),     32'(m_din));
        if (!RESET) begin
            if (busy) begin
                m_en = 1'b1; m_addr = 10'(DEPTH - m_left); m_din = COLOR; m_left--;
            end else if (win >= 0) begin
                m_en   = 1'b1;
                m_addr = (win == 1) ? REQ1_ADDR : REQ0_ADDR;
                m_din  = (win == 1) ? REQ1_DATA : REQ0_DATA;
                m_last = win;
            end else begin
                m_en = 1'b0;
            end
            if (!busy && CLR && CLEAR_START) m_left = DEPTH;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc();
        cyc();
        RESET = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        cyc();
        cyc();
        at_neg();
        chk("rst_en", 32'(FB_EN), 32'h0);
        chk("rst_addr", 32'(FB_ADDR), 32'h0);
        chk("rst_busy", 32'(CLEAR_BUSY), 32'h0);
        cyc();
        RESET = 1'b0;

        // single requester
        REQ0_VALID = 1'b1; REQ0_ADDR = 10'h005; REQ0_DATA = 24'h00FF00;
        at_neg();
        chk("single_ready", 32'(REQ0_READY), 32'h1);
        cyc();
        REQ0_VALID = 1'b0;
        at_neg();
        chk("single_we", 32'(FB_WE), 32'h1);
        chk("single_addr", 32'(FB_ADDR), 32'h005);
        chk("single_din", 32'(FB_DIN), 32'h00FF00);
        cyc();
        at_neg();
        chk("idle_en", 32'(FB_EN), 32'h0);
        chk("idle_hold", 32'(FB_ADDR), 32'h005);

        // contention straight after reset: REQ0, REQ1, REQ0, REQ1
        do_reset();
        REQ0_VALID = 1'b1; REQ0_ADDR = 10'h010; REQ0_DATA = 24'h000001;
        REQ1_VALID = 1'b1; REQ1_ADDR = 10'h020; REQ1_DATA = 24'h000002;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("cont_ready0", 32'(REQ0_READY), 32'((i % 2) == 0));
            chk("cont_ready1", 32'(REQ1_READY), 32'((i % 2) == 1));
            if (i > 0) chk("cont_addr", 32'(FB_ADDR), (i % 2) ? 32'h010 : 32'h020);
            cyc();
            if (i % 2) REQ1_DATA = REQ1_DATA + 24'h10;
            else REQ0_DATA = REQ0_DATA + 24'h10;
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        at_neg();
        chk("cont_last_addr", 32'(FB_ADDR), 32'h020);
        chk("cont_last_din", 32'(FB_DIN), 32'h000012);
        cyc();

`ifdef FB_WRITE_ARBITER_CLEAR_EN
        // clear colliding with REQ1, with an ignored restart pulse mid-sweep
        CLEAR_START = 1'b1;
        REQ1_VALID = 1'b1; REQ1_ADDR = 10'h3FF; REQ1_DATA = 24'h123456;
        at_neg();
        chk("coll_ready1", 32'(REQ1_READY), 32'h0);
        cyc();
        CLEAR_START = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(negedge CLK);
            if (!CLEAR_BUSY) break;
            n++;
            cyc();
            CLEAR_START = (n == 500);
        end
        #1;
        chk("clear_busy_cycles", 32'(n), 32'd1024);
        chk("after_ready1", 32'(REQ1_READY), 32'h1);
        chk("clear_last_addr", 32'(FB_ADDR), 32'h3FF);
        chk("clear_last_din", 32'(FB_DIN), 32'(COLOR));
        cyc();
        REQ1_VALID = 1'b0;
        at_neg();
        chk("coll_addr", 32'(FB_ADDR), 32'h3FF);
        chk("coll_din", 32'(FB_DIN), 32'h123456);
        cyc();

        // reset in the middle of a sweep
        CLEAR_START = 1'b1;
        cyc();
        CLEAR_START = 1'b0;
        repeat (301) cyc();
        at_neg();
        chk("mid_addr", 32'(FB_ADDR), 32'd300);
        RESET = 1'b1;
        #1;
        chk("mid_rst_en", 32'(FB_EN), 32'h0);
        chk("mid_rst_addr", 32'(FB_ADDR), 32'h0);
        chk("mid_rst_din", 32'(FB_DIN), 32'h0);
        chk("mid_rst_busy", 32'(CLEAR_BUSY), 32'h0);
        cyc();
        cyc();
        RESET = 1'b0;
        REQ0_VALID = 1'b1; REQ0_ADDR = 10'h155; REQ0_DATA = 24'hABCDEF;
        at_neg();
        chk("post_rst_ready0", 32'(REQ0_READY), 32'h1);
        cyc();
        REQ0_VALID = 1'b0;
        at_neg();
        chk("post_rst_addr", 32'(FB_ADDR), 32'h155);
        chk("post_rst_din", 32'(FB_DIN), 32'hABCDEF);
        cyc();
`else
        // without the clear feature CLEAR_START is inert
        CLEAR_START = 1'b1;
        REQ0_VALID = 1'b1; REQ0_ADDR = 10'h0AA; REQ0_DATA = 24'h0F0F0F;
        at_neg();
        chk("noclr_ready0", 32'(REQ0_READY), 32'h1);
        chk("noclr_busy", 32'(CLEAR_BUSY), 32'h0);
        cyc();
        CLEAR_START = 1'b0; REQ0_VALID = 1'b0;
        at_neg();
        chk("noclr_en", 32'(FB_EN), 32'h1);
        chk("noclr_addr", 32'(FB_ADDR), 32'h0AA);
        chk("noclr_din", 32'(FB_DIN), 32'h0F0F0F);
        cyc();
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("noclr_idle_en", 32'(FB_EN), 32'h0);
            chk("noclr_idle_busy", 32'(CLEAR_BUSY), 32'h0);
            cyc();
        end
`endif
        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
